ascon_permutation: RTL and testbench
====================================

Name: ascon_permutation

Overview:
- Iterative Ascon-p[rnd] permutation core over the 320-bit state. Executes one round per clock.
- Drives the round_counter's mode/incr inputs and consumes its rnd output as the round index.
- Sits directly downstream of round_counter, between it and the AEAD mode controller. The controller issues start and collects the permuted state.

Parameters:
- None. State width 320 and the round index type (4 bits) come from ascon_aead128_pkg.

Ports:
- clk  in  1  system clock, all state updates on posedge
- rst  in  1  asynchronous active-high reset
- start  in  1  request a permutation; accepted only when ready=1
- mode  in  1  P12_MODE or P8_MODE, sampled with an accepted start
- state_in  in  320  input state; x0=[319:256] ... x4=[63:0]; sampled with an accepted start
- ready  out  1  core idle and able to accept start
- valid  out  1  one-cycle pulse, state_out holds the permuted state
- state_out  out  320  permuted state, same word order as state_in
- cnt_mode  out  1  to round_counter.mode
- cnt_incr  out  1  to round_counter.incr (DO_INCR/NO_INCR)
- rnd  in  4  from round_counter.rnd; current round index

Behaviour:
- The round_counter in the same design sees reset as rst_n = ~rst. After reset its rnd = P12_INIT (4).
- Reset values: ready=1, valid=0, state_out=0, cnt_incr=NO_INCR, cnt_mode=P12_MODE, internal state=0, FSM=IDLE. Reset asserted mid-operation aborts the operation immediately; no valid is produced.
- FSM states: IDLE, ALIGN, RUN, DONE.
- IDLE:
  - ready=1, cnt_incr=0.
  - start=1: latch mode into mode_q, load state_in.
  - If rnd == init(mode), next state is RUN. Otherwise next state is ALIGN.
  - init(P12)=4, init(P8)=8.
  - start when ready=0 is ignored, with no queuing.
- ALIGN:
  - cnt_mode=mode_q, cnt_incr=1, state register unchanged.
  - rnd advances, reaches 15, then wraps to init(mode_q).
  - Leave for RUN in the cycle when the registered rnd == init(mode_q).
  - Worst case is 12 cycles (P8 requested with rnd=4).
- RUN:
  - cnt_mode=mode_q, cnt_incr=1.
  - Each cycle: state <= round(state, rnd).
  - If rnd==15, next state is DONE; the counter wraps to init(mode_q) on the same edge.
  - Round count is 12 for P12 and 8 for P8.
- DONE:
  - valid=1 for exactly one cycle, state_out=state, cnt_incr=0. Next state is IDLE.
  - state_out holds its value until the next DONE.
- round(x, r), with all operations on 64-bit words:
  - Constant: x2[7:0] ^= {4'(3-r), 4'(r-4)}, using modulo-16 nibble arithmetic (r=4 gives 0xF0, r=8 gives 0xB4, r=15 gives 0x4B).
  - Substitution layer: bitsliced 5-bit S-box.
    - x0^=x4; x4^=x3; x2^=x1.
    - ti = ~xi & x(i+1 mod 5) for i=0..4.
    - xi ^= t(i+1 mod 5) for i=0..4.
    - x1^=x0; x0^=x4; x3^=x2; x2=~x2.
  - Linear layer, all rotations right:
    - x0^=ror19^ror28
    - x1^=ror61^ror39
    - x2^=ror1^ror6
    - x3^=ror10^ror17
    - x4^=ror7^ror41
  - Entirely combinational within one cycle.
- Latency, counted from the start edge to the valid cycle:
  - Aligned P12: 13 cycles (12 RUN, then DONE).
  - Aligned P8: 9 cycles.
  - Unaligned: add the ALIGN cycles.
- Back-to-back operation: the earliest next start is the cycle after DONE, when ready=1 again.
- Ignored inputs: mode and state_in changing while ready=0 have no effect.

Test Plan:
- Reset, then start P12 with state_in=0. Required response:
  - RUN observes rnd 4..15.
  - cnt_incr high for exactly 12 cycles.
  - valid pulses 13 cycles after start.
  - state_out equals the bench SV model of p12(0).
  - ready=0 throughout the operation.
- After that P12, start P8. Required response:
  - ALIGN runs 12 cycles (rnd 4..15, then 8).
  - RUN runs 8 rounds, rnd 8..15.
  - state_out equals the model p8(state_in).
  - cnt_mode=P8_MODE during ALIGN and RUN.
- Two consecutive P8 starts. Required response:
  - The second start is aligned (rnd=8), so it has no ALIGN cycles.
  - Valid arrives 9 cycles after start.
- Start pulsed while busy, with different mode and state_in. Required response:
  - Ignored.
  - The result matches the first request.
  - Exactly one valid pulse.
- rst asserted in the 5th RUN cycle. Required response:
  - ready=1, valid=0, state_out=0 immediately.
  - A later P12 start with the counter back at 4 gives a correct result.
- Random states, 100 of each mode, compared against the SV model. Required response: every valid pulse matches the model, and no valid ever occurs without a preceding start.

Source files
------------

// File: rtl/ascon_permutation.sv
// Iterative Ascon-p[rnd] permutation core, one round per clock.
// Drives an external round counter and uses its rnd output as the round index.
module ascon_permutation (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [319:0] state_in,
  output logic         ready,
  output logic         valid,
  output logic [319:0] state_out,
  output logic         cnt_mode,
  output logic         cnt_incr,
  input  logic [3:0]   rnd
);

  localparam int unsigned STATE_W = 320;
  localparam int unsigned WORD_W  = 64;
  localparam int unsigned RND_W   = 4;

  localparam logic             P12_MODE = 1'b0;
  localparam logic             P8_MODE  = 1'b1;
  localparam logic             DO_INCR  = 1'b1;
  localparam logic             NO_INCR  = 1'b0;
  localparam logic [RND_W-1:0] P12_INIT = RND_W'(4);
  localparam logic [RND_W-1:0] P8_INIT  = RND_W'(8);
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(15);

  typedef enum logic [1:0] {IDLE, ALIGN, RUN, DONE} fsm_t;

  fsm_t               fsm;
  logic               mode_q;
  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] round_out_c;

  function automatic logic [RND_W-1:0] init_of(input logic m);
    return (m == P8_MODE) ? P8_INIT : P12_INIT;
  endfunction

  function automatic logic [WORD_W-1:0] ror64(input logic [WORD_W-1:0] x,
                                              input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  // One full round: constant addition, bitsliced S-box, linear diffusion.
  function automatic logic [STATE_W-1:0] ascon_round(input logic [STATE_W-1:0] s,
                                                     input logic [RND_W-1:0]   r);
    logic [WORD_W-1:0] x0, x1, x2, x3, x4;
    logic [WORD_W-1:0] t0, t1, t2, t3, t4;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128];
    x3 = s[127:64];
    x4 = s[63:0];
    x2[7:0] = x2[7:0] ^ {4'(4'd3 - r), 4'(r - 4'd4)};
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  assign round_out_c = ascon_round(state_q, rnd);

  // Control FSM; the counter wraps to init(mode_q) on the edge that leaves rnd=15.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      ready     <= 1'b1;
      valid     <= 1'b0;
      state_out <= '0;
      cnt_incr  <= NO_INCR;
      cnt_mode  <= P12_MODE;
      mode_q    <= P12_MODE;
      state_q   <= '0;
    end else begin
      valid <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            mode_q   <= mode;
            state_q  <= state_in;
            ready    <= 1'b0;
            cnt_mode <= mode;
            cnt_incr <= DO_INCR;
            fsm      <= (rnd == init_of(mode)) ? RUN : ALIGN;
          end
        end
        ALIGN: begin
          if (rnd == RND_LAST) fsm <= RUN;
        end
        RUN: begin
          state_q <= round_out_c;
          if (rnd == RND_LAST) begin
            fsm       <= DONE;
            cnt_incr  <= NO_INCR;
            valid     <= 1'b1;
            state_out <= round_out_c;
          end
        end
        DONE: begin
          ready <= 1'b1;
          fsm   <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_permutation.sv
// Directed bench for ascon_permutation with a behavioural round counter
// and a table-driven reference model of the Ascon permutation.
module tb_ascon_permutation;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         mode;
  logic [319:0] state_in;
  logic         ready;
  logic         valid;
  logic [319:0] state_out;
  logic         cnt_mode;
  logic         cnt_incr;
  logic [3:0]   rnd;
  logic         rst_n;

  int ncmp = 0;
  int nerr = 0;
  int n_valid = 0;
  int n_expect = 0;

  int           lat;
  int           incr_cyc;
  int           ready_bad;
  int           mode_bad;
  logic         timed_out;
  logic [319:0] res;
  logic [3:0]   rlog[$];

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  ascon_permutation dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .state_in  (state_in),
    .ready     (ready),
    .valid     (valid),
    .state_out (state_out),
    .cnt_mode  (cnt_mode),
    .cnt_incr  (cnt_incr),
    .rnd       (rnd)
  );

  always #5 clk = ~clk;

  // Round counter as seen by the core: counts to 15, then wraps to init(mode).
  assign rst_n = ~rst;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rnd <= 4'd4;
    else if (cnt_incr) rnd <= (rnd == 4'd15) ? (cnt_mode ? 4'd8 : 4'd4) : rnd + 4'd1;
  end

  always @(negedge clk) if (valid === 1'b1) n_valid++;

  function automatic logic [319:0] m_round(input logic [319:0] s, input int r);
    logic [63:0] x[5];
    logic [63:0] y[5];
    logic [4:0]  v, o;
    int          i;
    x[0] = s[319:256]; x[1] = s[255:192]; x[2] = s[191:128];
    x[3] = s[127:64];  x[4] = s[63:0];
    i = r - 4;
    x[2][7:0] = x[2][7:0] ^ 8'((((15 - i) & 15) << 4) | (i & 15));
    for (int j = 0; j < 64; j++) begin
      v = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
      o = SBOX[v];
      y[0][j] = o[4]; y[1][j] = o[3]; y[2][j] = o[2]; y[3][j] = o[1]; y[4][j] = o[0];
    end
    for (int w = 0; w < 5; w++)
      for (int j = 0; j < 64; j++)
        x[w][j] = y[w][j] ^ y[w][(j + ROT_A[w]) % 64] ^ y[w][(j + ROT_B[w]) % 64];
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [319:0] m_perm(input logic [319:0] s, input logic m);
    logic [319:0] t;
    t = s;
    for (int r = (m ? 8 : 4); r <= 15; r++) t = m_round(t, r);
    return t;
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] t;
    for (int k = 0; k < 10; k++) t[k*32 +: 32] = $urandom;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one start, follow it to valid, then step to the following idle cycle.
  task automatic do_op(input logic m, input logic [319:0] s, input int inj_cyc);
    int cyc;
    bit done;
    rlog.delete();
    incr_cyc = 0; ready_bad = 0; mode_bad = 0; lat = 0; done = 0; res = '0;
    start = 1'b1; mode = m; state_in = s;
    @(posedge clk); #1;
    start = 1'b0; mode = 1'($urandom); state_in = rand_state();
    cyc = 1;
    while (!done && cyc < 60) begin
      if (cnt_incr === 1'b1) begin
        incr_cyc++;
        rlog.push_back(rnd);
        if (cnt_mode !== m) mode_bad++;
      end
      if (ready !== 1'b0) ready_bad++;
      if (valid === 1'b1) begin
        done = 1; lat = cyc; res = state_out;
      end else begin
        if (cyc == inj_cyc) begin start = 1'b1; mode = ~m; state_in = ~s; end
        else start = 1'b0;
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    timed_out = !done;
    chk("no_timeout", timed_out, 1'b0);
    if (done) n_expect++;
    @(posedge clk); #1;
    chk("valid_one_cycle", valid, 1'b0);
    chk("ready_after_done", ready, 1'b1);
  endtask

  initial begin
    logic [319:0] s;
    int nv0;
    rst = 1'b1; start = 1'b0; mode = 1'b0; state_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1'b1);
    chk("rst_valid", valid, 1'b0);
    chk("rst_state_out", state_out, '0);
    chk("rst_cnt_incr", cnt_incr, 1'b0);
    chk("rst_cnt_mode", cnt_mode, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Aligned P12 on an all-zero state
    do_op(1'b0, '0, 0);
    chk("p12_latency", lat, 13);
    chk("p12_incr_cycles", incr_cyc, 12);
    chk("p12_first_rnd", rlog[0], 4'd4);
    chk("p12_last_rnd", rlog[11], 4'd15);
    chk("p12_ready_low", ready_bad, 0);
    chk("p12_cnt_mode", mode_bad, 0);
    chk("p12_result", res, m_perm('0, 1'b0));

    // P8 after P12 needs a full alignment pass of the counter
    s = 320'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0_deadbeefcafef00d;
    do_op(1'b1, s, 0);
    chk("p8_align_latency", lat, 21);
    chk("p8_align_incr_cycles", incr_cyc, 20);
    chk("p8_align_first_rnd", rlog[0], 4'd4);
    chk("p8_align_rnd15", rlog[11], 4'd15);
    chk("p8_run_first_rnd", rlog[12], 4'd8);
    chk("p8_run_last_rnd", rlog[19], 4'd15);
    chk("p8_cnt_mode", mode_bad, 0);
    chk("p8_ready_low", ready_bad, 0);
    chk("p8_result", res, m_perm(s, 1'b1));

    // Two consecutive aligned P8 runs
    for (int k = 0; k < 2; k++) begin
      s = rand_state();
      do_op(1'b1, s, 0);
      chk("p8_b2b_latency", lat, 9);
      chk("p8_b2b_incr_cycles", incr_cyc, 8);
      chk("p8_b2b_first_rnd", rlog[0], 4'd8);
      chk("p8_b2b_result", res, m_perm(s, 1'b1));
    end

    // Start pulsed while busy is ignored
    nv0 = n_valid;
    s = rand_state();
    do_op(1'b1, s, 3);
    repeat (20) @(posedge clk);
    #1;
    chk("busy_latency", lat, 9);
    chk("busy_result", res, m_perm(s, 1'b1));
    chk("busy_one_valid", n_valid - nv0, 1);

    // Reset in the 5th RUN cycle aborts the operation
    start = 1'b1; mode = 1'b1; state_in = rand_state();
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_run_rnd", rnd, 4'd12);
    rst = 1'b1;
    #1;
    chk("abort_ready", ready, 1'b1);
    chk("abort_valid", valid, 1'b0);
    chk("abort_state_out", state_out, '0);
    chk("abort_cnt_incr", cnt_incr, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    s = rand_state();
    do_op(1'b0, s, 0);
    chk("post_abort_latency", lat, 13);
    chk("post_abort_result", res, m_perm(s, 1'b0));

    // Random states, 100 per mode
    for (int k = 0; k < 100; k++) begin
      s = rand_state();
      do_op(1'b0, s, 0);
      chk("rand_p12_latency", lat, 13);
      chk("rand_p12_result", res, m_perm(s, 1'b0));
    end
    for (int k = 0; k < 100; k++) begin
      s = rand_state();
      do_op(1'b1, s, 0);
      chk("rand_p8_latency", lat, (k == 0) ? 21 : 9);
      chk("rand_p8_result", res, m_perm(s, 1'b1));
    end

    repeat (5) @(posedge clk);
    #1;
    chk("valid_pulse_count", n_valid, n_expect);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
